// File: rtl/sample_capture_ctrl.sv
// One-shot capture of decimated DDS samples into an external sample RAM with an optional
// rising-level trigger, followed by a valid/ready readout of the whole buffer.
module sample_capture_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              Fg_CLK,
    input  logic              RESETn,
    input  logic              Start,
    input  logic              Abort,
    input  logic              TrigEn,
    input  logic [DATA_W-1:0] TrigLevel,
    input  logic              SampleEn,
    input  logic [DATA_W-1:0] SampleIn,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [DATA_W-1:0] WrData,
    output logic [ADDR_W-1:0] RdAddr,
    input  logic [DATA_W-1:0] RdData,
    output logic              OutValid,
    output logic [DATA_W-1:0] OutData,
    output logic              OutLast,
    input  logic              OutReady,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        CAPTURE = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        RD_OUT  = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   count, count_nxt;
    logic [DATA_W-1:0] prev, prev_nxt;
    logic              prev_valid, prev_valid_nxt;

    logic              wr_en_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [DATA_W-1:0] wr_data_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic              out_valid_nxt;
    logic [DATA_W-1:0] out_data_nxt;
    logic              out_last_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    // Rising crossing needs a previous sample below the level and the current one at/above it.
    function automatic logic trig_cross(input logic              have_prev,
                                        input logic [DATA_W-1:0] prev_s,
                                        input logic [DATA_W-1:0] cur_s,
                                        input logic [DATA_W-1:0] level);
        return have_prev && (prev_s < level) && (cur_s >= level);
    endfunction

    always_comb begin
        state_nxt      = state;
        count_nxt      = count;
        prev_nxt       = prev;
        prev_valid_nxt = prev_valid;
        wr_en_nxt      = 1'b0;
        wr_addr_nxt    = WrAddr;
        wr_data_nxt    = WrData;
        rd_addr_nxt    = RdAddr;
        out_valid_nxt  = OutValid;
        out_data_nxt   = OutData;
        out_last_nxt   = OutLast;
        done_nxt       = 1'b0;

        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt      = ARM;
                    count_nxt      = '0;
                    prev_valid_nxt = 1'b0;
                end
            end
            ARM: begin
                if (SampleEn) begin
                    if (!TrigEn || trig_cross(prev_valid, prev, SampleIn, TrigLevel)) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = '0;
                        wr_data_nxt = SampleIn;
                        count_nxt   = (ADDR_W+1)'(1);
                        state_nxt   = CAPTURE;
                    end
                    if (TrigEn) begin
                        prev_nxt       = SampleIn;
                        prev_valid_nxt = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (SampleEn) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = count[ADDR_W-1:0];
                    wr_data_nxt = SampleIn;
                    count_nxt   = count + (ADDR_W+1)'(1);
                    if (&count[ADDR_W-1:0]) begin
                        state_nxt   = RD_ADDR;
                        rd_addr_nxt = '0;
                    end
                end
            end
            // RdAddr already holds the index here; the RAM returns it during RD_WAIT.
            RD_ADDR: state_nxt = RD_WAIT;
            RD_WAIT: begin
                state_nxt     = RD_OUT;
                out_data_nxt  = RdData;
                out_valid_nxt = 1'b1;
                out_last_nxt  = &RdAddr;
            end
            RD_OUT: begin
                if (OutValid && OutReady) begin
                    out_valid_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
                    if (OutLast) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        rd_addr_nxt = RdAddr + ADDR_W'(1);
                        state_nxt   = RD_ADDR;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Abort overrides everything, including a coincident write or final handshake.
        if (Abort) begin
            state_nxt      = IDLE;
            wr_en_nxt      = 1'b0;
            out_valid_nxt  = 1'b0;
            out_last_nxt   = 1'b0;
            done_nxt       = 1'b0;
            count_nxt      = '0;
            prev_nxt       = '0;
            prev_valid_nxt = 1'b0;
            rd_addr_nxt    = '0;
        end

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state      <= IDLE;
            count      <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            WrEn       <= 1'b0;
            WrAddr     <= '0;
            WrData     <= '0;
            RdAddr     <= '0;
            OutValid   <= 1'b0;
            OutData    <= '0;
            OutLast    <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            prev       <= prev_nxt;
            prev_valid <= prev_valid_nxt;
            WrEn       <= wr_en_nxt;
            WrAddr     <= wr_addr_nxt;
            WrData     <= wr_data_nxt;
            RdAddr     <= rd_addr_nxt;
            OutValid   <= out_valid_nxt;
            OutData    <= out_data_nxt;
            OutLast    <= out_last_nxt;
            Busy       <= busy_nxt;
            Done       <= done_nxt;
        end
    end

endmodule

// File: doc/sample_capture_ctrl.md
Name: sample_capture_ctrl

Overview:
Sequences one-shot capture of DDS output samples into an external single-port sample RAM. Sampling runs at the decimated rate set by the sampling strobe (SampleEn). Supports an optional rising-level trigger. After capture it streams the buffer to a readout consumer (display/UART) over a valid/ready handshake. Sits between the sampling-control strobe, the DDS output word, the sample RAM and the readout path.

Parameters:
ADDR_W, 8, RAM address width; DEPTH = 2**ADDR_W samples per capture
DATA_W, 8, sample width

Ports:
Fg_CLK  in  1  system clock
RESETn  in  1  async active-low reset
Start  in  1  1-cycle pulse; begins a capture
Abort  in  1  1-cycle pulse; cancels any operation
TrigEn  in  1  1 = wait for trigger crossing; 0 = capture immediately
TrigLevel  in  DATA_W  trigger threshold, unsigned
SampleEn  in  1  decimated sample strobe, 1 cycle wide
SampleIn  in  DATA_W  current DDS sample
WrEn  out  1  RAM write strobe
WrAddr  out  ADDR_W  RAM write address
WrData  out  DATA_W  RAM write data
RdAddr  out  ADDR_W  RAM read address; RdData valid 1 cycle later
RdData  in  DATA_W  RAM read data
OutValid  out  1  readout sample valid
OutData  out  DATA_W  readout sample
OutLast  out  1  marks sample DEPTH-1, qualified by OutValid
OutReady  in  1  consumer accepts when OutValid&OutReady
Busy  out  1  1 in any state except IDLE
Done  out  1  1-cycle pulse after the last readout transfer

Behaviour:
- Reset: RESETn is asynchronous, active-low, clock is Fg_CLK. State=IDLE. All outputs 0. Internal counters 0. prev_valid=0.
- States: IDLE, ARM, CAPTURE, RD_ADDR, RD_WAIT, RD_OUT. All are registered, and every output is registered.
- IDLE: a Start pulse moves to ARM, clears the sample count, and clears prev_valid. Start is ignored in every other state.
- ARM, TrigEn=0: the first SampleEn writes SampleIn to address 0, sets count=1, and moves to CAPTURE.
- ARM, TrigEn=1: on each SampleEn, prev <= SampleIn and prev_valid <= 1.
  - Trigger fires when prev_valid=1 and prev < TrigLevel and SampleIn >= TrigLevel.
  - The triggering sample is written to address 0, count=1, and the state moves to CAPTURE.
  - The first SampleEn after entering ARM never triggers.
- TrigEn is sampled on every SampleEn while in ARM, so a change takes effect at the next strobe.
- CAPTURE: on each SampleEn, write SampleIn at WrAddr=count[ADDR_W-1:0], then count++.
  - The count register is ADDR_W+1 bits wide.
  - After the write at address DEPTH-1, the state moves to RD_ADDR with read index=0.
- Write timing: WrEn/WrAddr/WrData are asserted for exactly one cycle, the cycle after the accepted SampleEn. WrEn is never high in any other state.
- RD_ADDR: drive RdAddr=index, then go to RD_WAIT.
- RD_WAIT: one cycle for RAM latency, then go to RD_OUT.
- Entering RD_OUT: OutData<=RdData and OutValid<=1. OutLast<=(index==DEPTH-1).
- RD_OUT: OutData/OutLast are held stable while OutValid=1 and OutReady=0.
  - On OutValid&OutReady, OutValid drops the next cycle.
  - If not last: index++ and return to RD_ADDR.
  - If last: Done=1 for one cycle and return to IDLE.
- Readout throughput: at most one sample per 3 cycles with OutReady tied high.
- SampleEn is ignored outside ARM/CAPTURE. Samples arriving during readout are lost by design.
- Abort in any state: next cycle state=IDLE, WrEn=0, OutValid=0, OutLast=0, no Done. Counters and prev_valid are cleared.
  - Abort and Start in the same cycle in IDLE: Abort wins and the state stays IDLE.
  - Abort coincident with a SampleEn in CAPTURE: no write is issued.
  - Abort coincident with the final OutReady: the transfer counts as accepted, but Done is suppressed.
- Reset mid-operation: returns immediately to the reset values. RAM contents are not touched.
- Busy = (state != IDLE), registered so it aligns with the state.

Test Plan:
1. ADDR_W=2, TrigEn=0, Start, then SampleEn with SampleIn=0x10,0x20,0x30,0x40 -> WrEn 4 times at addr 0..3 with those data. Busy=1 from the cycle after Start. RD sequence begins after the 4th write.
2. Continue 1 with a RAM model and OutReady=1 -> OutData 0x10,0x20,0x30,0x40. OutLast only on 0x40. Done pulses once, then Busy=0.
3. TrigEn=1, TrigLevel=0x80, samples 0x90,0x70,0x7F,0x80,0x85,... -> no trigger on 0x90 (first) or 0x70. Trigger on 0x80, which is written to addr 0. 0x85 goes to addr 1.
4. Readout with OutReady low for 5 cycles on sample 2 -> OutValid and OutData=0x30 held stable. Transfer completes on OutReady=1. No sample is skipped or duplicated.
5. Abort during CAPTURE after 2 writes, coincident with SampleEn -> no third write, IDLE next cycle, Busy=0, no Done. A new Start writes again from addr 0.
6. Start while in CAPTURE is ignored. Start+Abort in IDLE stays IDLE. RESETn low during RD_OUT -> all outputs 0 asynchronously.
